// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // Slot register-address width; any REG_AW up to this value is zero-extended into it.
    localparam int SLOT_AW = 8;

    // Stage in which a branch/jump resolves.
    localparam int BR_EXE = 1;
    localparam int BR_MEM = 2;

    // EXE operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Shadow copy of one in-flight instruction's hazard-relevant fields.
    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_to_reg;
        logic [SLOT_AW-1:0] dst;
        logic [SLOT_AW-1:0] rs;
        logic [SLOT_AW-1:0] rt;
        logic               use_rs;
        logic               use_rt;
    } shadow_slot_t;

    // A slot produces a forwardable result only if it really writes a non-zero register.
    function automatic logic slot_live(input shadow_slot_t s);
        return s.valid & s.reg_write & (s.dst != '0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one EXE source: the youngest live producer wins.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [SLOT_AW-1:0] i_src,
    input  logic               i_use,
    input  shadow_slot_t       i_mem,
    input  shadow_slot_t       i_wb,
    output fwd_sel_t           o_sel
);

    // Only the write-back fields of the producer slots matter here.
    logic w_unused;
    assign w_unused = ^{i_mem.mem_to_reg, i_mem.rs, i_mem.rt, i_mem.use_rs, i_mem.use_rt,
                        i_wb.mem_to_reg,  i_wb.rs,  i_wb.rt,  i_wb.use_rs,  i_wb.use_rt};

    // MEM result is newer than WB result, so it takes precedence on a double match.
    always_comb begin
        o_sel = FWD_RF;
        if (i_use) begin
            if (slot_live(i_mem) && (i_mem.dst == i_src)) begin
                o_sel = FWD_MEM;
            end else if (slot_live(i_wb) && (i_wb.dst == i_src)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Optional macro HAZ_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int BR_STAGE = 2,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              br_taken,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic BR_AT_MEM = (BR_STAGE == BR_MEM);

    shadow_slot_t r_ex, r_mem, r_wb;
    shadow_slot_t w_id;
    logic         w_load_use;
    logic         w_ex_hit;
    fwd_sel_t     w_fwd_a, w_fwd_b;

    // Pack the ID instruction into slot form.
    always_comb begin
        w_id            = '0;
        w_id.valid      = id_valid;
        w_id.reg_write  = id_reg_write;
        w_id.mem_to_reg = id_mem_to_reg;
        w_id.dst        = SLOT_AW'(id_dst);
        w_id.rs         = SLOT_AW'(id_rs);
        w_id.rt         = SLOT_AW'(id_rt);
        w_id.use_rs     = id_use_rs;
        w_id.use_rt     = id_use_rt;
    end

    // A load in EX whose result a used ID source needs cannot be forwarded in time.
    always_comb begin
        w_ex_hit   = (id_use_rs && (r_ex.dst == w_id.rs)) ||
                     (id_use_rt && (r_ex.dst == w_id.rt));
        w_load_use = id_valid && slot_live(r_ex) && r_ex.mem_to_reg && w_ex_hit;
    end

    // Priority: reset, freeze, taken flush, load-use stall, normal advance.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!clr) begin
            if (mem_busy) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else if (br_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = BR_AT_MEM;
            end else if (w_load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    // Shadow slots follow the real pipeline registers: hold on freeze, bubble on flush/stall.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_ex.valid  <= 1'b0;
            r_mem.valid <= 1'b0;
            r_wb.valid  <= 1'b0;
        end else if (!mem_busy) begin
            r_wb  <= r_mem;
            r_mem <= (br_taken && BR_AT_MEM) ? '0 : r_ex;
            r_ex  <= (br_taken || w_load_use) ? '0 : w_id;
        end
    end

    fwd_sel u_fwd_a (
        .i_src (r_ex.rs),
        .i_use (r_ex.valid & r_ex.use_rs),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .i_src (r_ex.rt),
        .i_use (r_ex.valid & r_ex.use_rt),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (w_fwd_b)
    );

    assign fwd_a = clr ? 2'b00 : w_fwd_a;
    assign fwd_b = clr ? 2'b00 : w_fwd_b;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // Saturating event counters; a frozen cycle is not an event.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_busy) begin
            if (br_taken) begin
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else if (w_load_use) begin
                if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (BR_STAGE=2 main DUT, BR_STAGE=1 companion).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_to_reg;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       br_taken, mem_busy;

    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1;
    logic       ifid_flush1, idex_flush1, exmem_flush1;
    logic [1:0] fwd_a1, fwd_b1;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(2), .CNT_W(32)) dut (
        .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_dst(id_dst), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZ_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(1), .CNT_W(32)) dut1 (
        .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_dst(id_dst), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .idex_en(idex_en1), .exmem_en(exmem_en1), .memwb_en(memwb_en1),
        .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .exmem_flush(exmem_flush1),
        .fwd_a(fwd_a1), .fwd_b(fwd_b1)
`ifdef HAZ_PERF_EN
        , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
    );

    // Grouped views: enables {pc,ifid,idex,exmem,memwb}, flushes {ifid,idex,exmem}.
    wire [4:0] en  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    wire [2:0] fl  = {ifid_flush, idex_flush, exmem_flush};
    wire [2:0] fl1 = {ifid_flush1, idex_flush1, exmem_flush1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic rw,
                          input logic m2r, input logic [4:0] dst);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_reg_write = rw; id_mem_to_reg = m2r; id_dst = dst;
        #1;
    endtask

    task automatic nop;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset;
        clr = 1'b1; br_taken = 1'b0; mem_busy = 1'b0;
        nop();
        tick();
        clr = 1'b0;
        #1;
    endtask

    initial begin
        // Reset: outputs forced even with freeze/branch requested.
        clr = 1'b1; br_taken = 1'b1; mem_busy = 1'b1;
        nop();
        chk("rst_en", 32'(en), 32'h1f);
        chk("rst_fl", 32'(fl), 32'h0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
        do_reset();

        // Forward from MEM.
        set_id(1, 16, 17, 1, 1, 1, 0, 8);   // add $8,$16,$17
        tick();
        set_id(1, 8, 18, 1, 1, 1, 0, 9);    // add $9,$8,$18
        chk("mem_nostall", 32'(en), 32'h1f);
        tick();
        nop();
        chk("mem_fwd_a", 32'(fwd_a), 32'h2);
        chk("mem_fwd_b", 32'(fwd_b), 32'h0);

        // Forward from WB.
        do_reset();
        set_id(1, 16, 17, 1, 1, 1, 0, 8); tick();
        nop(); tick();
        set_id(1, 8, 8, 1, 1, 1, 0, 9); tick();  // sub $9,$8,$8
        nop();
        chk("wb_fwd", 32'({fwd_a, fwd_b}), 32'h5);

        // Destination $0 is never forwarded.
        do_reset();
        set_id(1, 16, 17, 1, 1, 1, 0, 0); tick();
        nop(); tick();
        set_id(1, 0, 0, 1, 1, 1, 0, 9); tick();
        nop();
        chk("r0_fwd", 32'({fwd_a, fwd_b}), 32'h0);

        // MEM producer is newer than WB producer.
        do_reset();
        set_id(1, 16, 17, 1, 1, 1, 0, 8); tick();
        set_id(1, 18, 19, 1, 1, 1, 0, 8); tick();
        set_id(1, 8, 8, 1, 1, 1, 0, 9); tick();
        nop();
        chk("mem_over_wb", 32'({fwd_a, fwd_b}), 32'ha);

        // Load-use: exactly one stall cycle, then WB forwarding.
        do_reset();
        set_id(1, 0, 0, 1, 0, 1, 1, 8);     // lw $8,0($0)
        chk("lw_nostall", 32'(en), 32'h1f);
        tick();
        set_id(1, 8, 16, 1, 1, 1, 0, 9);    // add $9,$8,$16
        chk("lu_en", 32'(en), 32'h07);
        chk("lu_fl", 32'(fl), 32'h2);
        tick();
        chk("lu_once_en", 32'(en), 32'h1f);
        chk("lu_once_fl", 32'(fl), 32'h0);
        tick();
        nop();
        chk("lu_fwd_a", 32'(fwd_a), 32'h1);
        chk("lu_fwd_b", 32'(fwd_b), 32'h0);
`ifdef HAZ_PERF_EN
        chk("lu_stall_cnt", stall_cnt, 32'd1);
`endif

        // Taken branch: squash and no forwarding from squashed slots.
        do_reset();
        set_id(1, 16, 17, 1, 1, 1, 0, 8); tick();
        set_id(1, 8, 18, 1, 1, 1, 0, 9); tick();
        set_id(1, 9, 8, 1, 1, 1, 0, 10);
        br_taken = 1'b1; #1;
        chk("br_fl", 32'(fl), 32'h7);
        chk("br_pc_en", 32'(pc_en), 32'h1);
        chk("br1_fl", 32'(fl1), 32'h6);
        tick();
        br_taken = 1'b0;
        set_id(1, 9, 8, 1, 1, 1, 0, 12); tick();
        nop();
        chk("br_nofwd", 32'({fwd_a, fwd_b}), 32'h0);
        chk("br1_fwd", 32'({fwd_a1, fwd_b1}), 32'h4);
`ifdef HAZ_PERF_EN
        chk("br_flush_cnt", flush_cnt, 32'd1);
`endif

        // Flush and load-use together: flush wins.
        do_reset();
        set_id(1, 0, 0, 1, 0, 1, 1, 8); tick();
        set_id(1, 8, 16, 1, 1, 1, 0, 9);
        br_taken = 1'b1; #1;
        chk("fl_lu_fl", 32'(fl), 32'h7);
        chk("fl_lu_en", 32'(en), 32'h1f);
        tick();
        br_taken = 1'b0;
        nop();
`ifdef HAZ_PERF_EN
        chk("fl_lu_stall_cnt", stall_cnt, 32'd0);
        chk("fl_lu_flush_cnt", flush_cnt, 32'd1);
`endif

        // Freeze with a pending branch, then release.
        do_reset();
        set_id(1, 16, 17, 1, 1, 1, 0, 8); tick();
        set_id(1, 8, 18, 1, 1, 1, 0, 9); tick();
        nop();
        mem_busy = 1'b1; br_taken = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("frz_en", 32'(en), 32'h0);
            chk("frz_fl", 32'(fl), 32'h0);
            chk("frz_hold", 32'(fwd_a), 32'h2);
            tick();
        end
        mem_busy = 1'b0; #1;
        chk("rel_fl", 32'(fl), 32'h7);
        chk("rel_en", 32'(en), 32'h1f);
        tick();
        br_taken = 1'b0; #1;
        chk("rel_fl_once", 32'(fl), 32'h0);
`ifdef HAZ_PERF_EN
        chk("frz_flush_cnt", flush_cnt, 32'd1);
        chk("frz_stall_cnt", stall_cnt, 32'd0);
`endif

        // Reset in the middle of a freeze.
        set_id(1, 16, 17, 1, 1, 1, 0, 8); tick();
        set_id(1, 8, 18, 1, 1, 1, 0, 9); tick();
        nop();
        mem_busy = 1'b1; tick();
        clr = 1'b1; #1;
        chk("clr_frz_en", 32'(en), 32'h1f);
        chk("clr_frz_fwd", 32'(fwd_a), 32'h0);
        tick();
        clr = 1'b0; mem_busy = 1'b0; #1;
        chk("post_clr_fwd", 32'({fwd_a, fwd_b}), 32'h0);
        chk("post_clr_en", 32'(en), 32'h1f);
`ifdef HAZ_PERF_EN
        chk("post_clr_flush_cnt", flush_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
